pipe_xy_sink: RTL and testbench
===============================

# pipe_xy_sink

Receiving end for the two-bit result stream (X, Y) produced by the team's pipeline blocks. Accepts one (x, y) pair per handshake and packs PAIRS consecutive pairs into one word. Buffers completed words in a small show-ahead FIFO and presents them to a downstream consumer over a valid/ready interface. Sits directly behind a pipeline's X/Y outputs so results are collected, framed and back-pressured instead of sampled by hand.

## Interface
- PAIRS, 4, pairs packed per output word; word width W = 2*PAIRS; PAIRS >= 2
- DEPTH, 4, FIFO depth in words; power of two, >= 2
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  x/y pair valid
- in_ready  out  1  sink can accept a pair this cycle
- x  in  1  result bit X
- y  in  1  result bit Y
- flush  in  1  synchronous; discards the partially assembled word
- out_valid  out  1  out_data holds the oldest buffered word
- out_ready  in  1  consumer takes the word this cycle
- out_data  out  W  oldest word; 0 whenever out_valid = 0
- count  out  $clog2(DEPTH+1)  words currently buffered
- words_total  out  16  completed words pushed since reset; wraps 65535 -> 0

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Packing: pair k (0-based, in arrival order) lands at bits [2k+1:2k], with x at bit 2k+1 and y at bit 2k.
- Assembler FSM, pair_idx 0..PAIRS-1:
  - EMPTY (pair_idx = 0): accept -> FILL, pair_idx = 1.
  - FILL: each accept increments pair_idx.
  - Accepting pair PAIRS-1 pushes the full word into the FIFO, clears the partial register and returns to EMPTY.
- in_ready = !flush && (pair_idx != PAIRS-1 || count != DEPTH).
  - A pop in the same cycle does not raise in_ready; there is no combinational path from out_ready.
- Pop: out_valid && out_ready. The read pointer advances and count decrements.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- flush:
  - Returns the FSM to EMPTY and zeroes the partial word.
  - Forces in_ready = 0, so any pair offered that cycle is dropped.
  - FIFO contents, count and words_total are unaffected; a pop in the same cycle still completes.
- words_total increments on every push.
- reset, asserted at any time including mid-word or mid-pop:
  - Immediately clears pair_idx, partial word, pointers, count and words_total.
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, count = 0, words_total = 0.
  - FIFO storage is not cleared; out_data gating hides it.

## Timing
- Word latency: the edge that accepts the last pair pushes the word; out_valid and out_data are valid immediately after that edge (1 cycle).
- Throughput: one pair per cycle sustained while the FIFO is not full; one word per PAIRS cycles.
- Full FIFO with pair_idx = PAIRS-1: in_ready = 0 until the edge after a pop.
- out_data, out_valid and count are register/memory-read driven with no dependence on in_valid or out_ready in the same cycle.
- Earlier pairs (pair_idx < PAIRS-1) are still accepted while the FIFO is full.

## Structure
- Package pipe_sink_pkg:
  - PAIR_W = 2
  - typedef pair_t (logic [1:0], {x, y})
  - typedef enum asm_state_t {EMPTY, FILL}
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - Show-ahead, registered pointers and count.
  - Ports: clk, reset, push, push_data, pop, rd_data, count, full, empty.
- Top level holds the assembler FSM, the partial-word register, in_ready logic, out_data gating and words_total.

## Test plan
- Reset then pairs (1,1),(0,1),(1,0),(0,0) on consecutive cycles, out_ready = 1 -> out_valid high one cycle after the 4th accept; out_data = 8'h27; words_total = 1; count returns to 0 after the pop.
- out_ready = 0, stream 5 words of all (1,1) -> count = 4 after 16 pairs.
  - in_ready drops at the 20th pair (pair_idx = 3, full) and stays low.
  - One pop re-raises in_ready on the next cycle; the 5th word (8'hFF) is pushed.
- Send (1,0),(1,0), then flush with in_valid = 1 on pair (0,1) -> pair dropped (in_ready = 0); next 4 pairs (0,1)x4 yield 8'h55; no word contains the discarded half.
- Full FIFO, simultaneous pop and push of the last pair is not possible; check a push with a pop at count = 2 -> count stays 2, order of words preserved.
- Assert reset mid-word (pair_idx = 2) with count = 3 -> out_valid = 0, out_data = 0, count = 0, in_ready = 1 immediately (asynchronously); next 4 pairs form a fresh word.
- Preload words_total to 65535 via 65535 words (or force) and push one more -> words_total = 0.

Source files
------------

// File: rtl/pipe_sink_pkg.sv
// Shared types for the X/Y result sink: pair encoding and assembler states.
package pipe_sink_pkg;

  localparam int PAIR_W = 2;

  typedef logic [PAIR_W-1:0] pair_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } asm_state_t;

  function automatic pair_t make_pair(input logic x, input logic y);
    return {x, y};
  endfunction

endpackage

// File: rtl/pipe_xy_sink_sync_fifo.sv
// Show-ahead synchronous FIFO with registered pointers and occupancy count.
// Storage is not reset; the consumer is expected to gate rd_data with empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pipe_xy_sink.sv
// Collects (x, y) result pairs, packs PAIRS of them per word (pair k at bits
// [2k+1:2k]) and hands completed words downstream through a show-ahead FIFO.
module pipe_xy_sink
  import pipe_sink_pkg::*;
#(
  parameter int PAIRS = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       x,
  input  logic                       y,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*PAIRS-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                words_total
);

  localparam int W  = PAIR_W * PAIRS;
  localparam int IW = $clog2(PAIRS);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAIRS-1);

  asm_state_t               state_q, state_d;
  logic [IW-1:0]            pair_idx_q, pair_idx_d;
  logic [W-1:0]             partial_q, partial_d;
  logic [15:0]              words_total_q, words_total_d;

  pair_t                    pair_s;
  logic [W-1:0]             shifted_pair_s;
  logic                     accept_s, push_s, pop_s;
  logic [W-1:0]             push_data_s;
  logic [W-1:0]             fifo_rd_data_s;
  logic [$clog2(DEPTH+1)-1:0] fifo_count_s;
  logic                     fifo_full_s, fifo_empty_s;

  // The final pair is only refused when its word would have nowhere to go.
  assign in_ready       = !flush && ((pair_idx_q != LAST_IDX) || !fifo_full_s);
  assign pair_s         = make_pair(x, y);
  assign shifted_pair_s = W'(pair_s) << (PAIR_W * int'(pair_idx_q));
  assign accept_s       = in_valid && in_ready;
  assign push_s         = accept_s && (pair_idx_q == LAST_IDX);
  assign push_data_s    = partial_q | shifted_pair_s;
  assign pop_s          = out_valid && out_ready;

  assign out_valid   = !fifo_empty_s;
  assign out_data    = out_valid ? fifo_rd_data_s : {W{1'b0}};
  assign count       = fifo_count_s;
  assign words_total = words_total_q;

  // Assembler next-state: flush wins over any offered pair.
  always_comb begin
    state_d    = state_q;
    pair_idx_d = pair_idx_q;
    partial_d  = partial_q;
    if (flush) begin
      state_d    = EMPTY;
      pair_idx_d = IW'(0);
      partial_d  = {W{1'b0}};
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            state_d    = FILL;
            pair_idx_d = IW'(1);
            partial_d  = shifted_pair_s;
          end else begin
            state_d = EMPTY;
          end
        end
        FILL: begin
          if (push_s) begin
            state_d    = EMPTY;
            pair_idx_d = IW'(0);
            partial_d  = {W{1'b0}};
          end else if (accept_s) begin
            pair_idx_d = pair_idx_q + IW'(1);
            partial_d  = push_data_s;
          end else begin
            state_d = FILL;
          end
        end
        default: begin
          state_d    = EMPTY;
          pair_idx_d = IW'(0);
          partial_d  = {W{1'b0}};
        end
      endcase
    end
  end

  // Completed-word counter next-state.
  always_comb begin
    words_total_d = words_total_q;
    if (push_s) begin
      words_total_d = words_total_q + 16'd1;
    end else begin
      words_total_d = words_total_q;
    end
  end

  // Assembler and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      pair_idx_q    <= IW'(0);
      partial_q     <= {W{1'b0}};
      words_total_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pair_idx_q    <= pair_idx_d;
      partial_q     <= partial_d;
      words_total_q <= words_total_d;
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .rd_data   (fifo_rd_data_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: tb/tb_pipe_xy_sink.sv
// Scoreboard bench for pipe_xy_sink: directed scenarios plus random traffic
// checked against a pair-list / word-queue reference model.
module tb_pipe_xy_sink;

  localparam int PAIRS = 4;
  localparam int DEPTH = 4;
  localparam int W     = 2 * PAIRS;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, in_valid, x, y, flush, out_ready;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic [15:0]   words_total;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q [$];
  logic [1:0]   m_pairs [$];
  logic [15:0]  m_wt = 16'd0;

  pipe_xy_sink #(.PAIRS(PAIRS), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .words_total (words_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor + reference model: compare at the falling edge, then advance the model.
  always @(negedge clk) begin : monitor
    logic e_rdy;
    int   w;
    if (reset) begin
      exp_q.delete();
      m_pairs.delete();
      m_wt = 16'd0;
    end else begin
      e_rdy = !flush && (m_pairs.size() != PAIRS - 1 || exp_q.size() != DEPTH);
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      chk("out_valid", {31'd0, out_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
      chk("out_data", {24'd0, out_data}, (exp_q.size() != 0) ? {24'd0, exp_q[0]} : 32'd0);
      chk("count", {29'd0, count}, exp_q.size());
      chk("words_total", {16'd0, words_total}, {16'd0, m_wt});
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (flush) begin
        m_pairs.delete();
      end else if (in_valid && e_rdy) begin
        m_pairs.push_back({x, y});
        if (m_pairs.size() == PAIRS) begin
          w = 0;
          for (int k = 0; k < PAIRS; k++) w = w + int'(m_pairs[k]) * (1 << (2 * k));
          exp_q.push_back(w[W-1:0]);
          m_wt = m_wt + 16'd1;
          m_pairs.delete();
        end
      end
    end
  end

  task automatic drive(input logic v, input logic xv, input logic yv, input logic f, input logic r);
    in_valid  = v;
    x         = xv;
    y         = yv;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; x = 1'b0; y = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_words_total", {16'd0, words_total}, 32'd0);
    reset = 1'b0;
    idle(2, 1'b1);

    // Basic packing: (1,1),(0,1),(1,0),(0,0) -> 8'h27.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_word", {24'd0, out_data}, 32'h27);
    chk("first_total", {16'd0, words_total}, 32'd1);
    @(posedge clk); #1;
    idle(2, 1'b1);

    // Fill the FIFO with all-ones words until the last pair is blocked.
    for (int i = 0; i < 22; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_blocked", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("reopen_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    idle(8, 1'b1);

    // Flush discards a half-built word and drops the pair offered with it.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1; x = 1'b0; y = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_word", {24'd0, out_data}, 32'h55);
    @(posedge clk); #1;
    idle(3, 1'b1);

    // Simultaneous push and pop at count 2.
    for (int i = 0; i < 11; i++) drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_count", {29'd0, count}, 32'd2);
    @(posedge clk); #1;
    idle(4, 1'b1);

    // Asynchronous reset mid-word with three words buffered.
    for (int i = 0; i < 14; i++) drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b1);
    idle(3, 1'b1);

    // words_total wrap: preload 65535, then complete one more word.
    force dut.words_total_q = 16'hFFFF;
    m_wt = 16'hFFFF;
    #1;
    release dut.words_total_q;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_total", {16'd0, words_total}, 32'd0);
    @(posedge clk); #1;
    idle(3, 1'b1);

    // Random traffic with occasional flushes and back-pressure.
    for (int i = 0; i < 600; i++)
      drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(15) == 0), 1'($urandom_range(2) != 0));
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
